// File: rtl/aes_out_pkg.sv
// Shared types and sizing helpers for the AES text_out serializer.
package aes_out_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int nwords(input int block_w, input int word_w);
        return block_w / word_w;
    endfunction

    // Width of an index over n items; never below 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aes_block_fifo.sv
// DEPTH x W block FIFO; pointers wrap modulo DEPTH so any DEPTH >= 1 works.
module aes_block_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    // A push into a full FIFO is legal only when the head leaves the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/aes_text_out_serializer.sv
// Captures cipher text_out blocks on done, buffers them, and streams each
// block MSB-word first over a valid/ready port, flagging dropped blocks.
module aes_text_out_serializer
    import aes_out_pkg::*;
#(
    parameter int BLOCK_W = 128,
    parameter int WORD_W  = 32,
    parameter int DEPTH   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       done,
    input  logic [BLOCK_W-1:0]         text_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORD_W-1:0]          out_data,
    output logic                       out_last,
    output logic [$clog2(DEPTH+1)-1:0] blk_count,
    output logic                       full,
    output logic                       overflow,
    input  logic                       clr_ovf,
    output state_t                     state_dbg
);

    localparam int NW    = nwords(BLOCK_W, WORD_W);
    localparam int IDX_W = idx_w(NW);
    localparam int CNT_W = $clog2(DEPTH+1);

    generate
        if (BLOCK_W % WORD_W != 0) begin : g_bad_width
            $error("BLOCK_W must be a multiple of WORD_W");
        end
        if (DEPTH < 1) begin : g_bad_depth
            $error("DEPTH must be at least 1");
        end
    endgenerate

    state_t                       state, state_nx;
    logic [IDX_W-1:0]             idx, idx_nx;
    logic [BLOCK_W-1:0]           head;
    logic [NW-1:0][WORD_W-1:0]    words;
    logic [CNT_W-1:0]             count;
    logic                         fifo_full, fifo_empty;
    logic                         is_last, hs, pop, push, drop;

    // Valid/ready: a word transfers on a cycle where out_valid && out_ready;
    // while out_valid is high and out_ready low, out_data/out_last hold.
    assign is_last = (idx == IDX_W'(NW-1));
    assign hs      = (state == SEND) && out_ready;
    assign pop     = hs && is_last && !fifo_empty;
    assign push    = done && (!fifo_full || pop);
    assign drop    = done && !push;

    aes_block_fifo #(
        .W     (BLOCK_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (text_out),
        .rdata (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Packed word view: words[NW-1] is the most significant word (word 0).
    assign words = head;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                if (push) begin
                    state_nx = SEND;
                    idx_nx   = '0;
                end
            end
            SEND: begin
                if (hs) begin
                    if (is_last) begin
                        idx_nx   = '0;
                        state_nx = (count > CNT_W'(1) || push) ? SEND : IDLE;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                idx_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    assign out_valid = (state == SEND);
    assign out_data  = out_valid ? words[IDX_W'(NW-1) - idx] : '0;
    assign out_last  = out_valid && is_last;
    assign blk_count = count;
    assign full      = fifo_full;
    assign state_dbg = state;

endmodule
